// File: rtl/fp_custom_accumulator.sv
// Two-stage multi-lane accumulator for the {sign, exp, fxp} format: a fixed-order
// adder tree per beat, then a running sum released as one normalized word per vector.
module fp_custom_accumulator #(
  parameter int FXP_WIDTH = 12,
  parameter int EXP_WIDTH = 5,
  parameter int FP_WIDTH  = FXP_WIDTH + EXP_WIDTH + 1,
  parameter int LANES     = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*FP_WIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FP_WIDTH-1:0]       out_data,
  output logic                      out_overflow,
  output logic                      busy
);

  localparam int SHIFT_LIM = FXP_WIDTH + 1;

  // Returns {overflow, word}; the operand with the strictly larger exponent is the anchor.
  function automatic logic [FP_WIDTH:0] fp_add(input logic [FP_WIDTH-1:0] x,
                                               input logic [FP_WIDTH-1:0] y);
    logic                        s_max, s_min, sgn, carry;
    logic [EXP_WIDTH-1:0]        e_max, e_min, shift, e_n;
    logic [FXP_WIDTH-1:0]        m_max, m_min, fx;
    logic signed [FXP_WIDTH:0]   t_max, t_min, t_sh;
    logic signed [FXP_WIDTH+1:0] sum;
    logic [FXP_WIDTH+1:0]        abs_v;
    logic [EXP_WIDTH:0]          e_w;
    logic [FP_WIDTH:0]           res;
    if (x[FXP_WIDTH +: EXP_WIDTH] > y[FXP_WIDTH +: EXP_WIDTH]) begin
      {s_max, e_max, m_max} = x;
      {s_min, e_min, m_min} = y;
    end else begin
      {s_max, e_max, m_max} = y;
      {s_min, e_min, m_min} = x;
    end
    t_max = s_max ? -$signed({1'b0, m_max}) : $signed({1'b0, m_max});
    t_min = s_min ? -$signed({1'b0, m_min}) : $signed({1'b0, m_min});
    shift = e_max - e_min;
    if (32'(shift) >= SHIFT_LIM) begin
      t_sh = t_min[FXP_WIDTH] ? {(FXP_WIDTH+1){1'b1}} : {(FXP_WIDTH+1){1'b0}};
    end else begin
      t_sh = t_min >>> shift;
    end
    sum   = {t_max[FXP_WIDTH], t_max} + {t_sh[FXP_WIDTH], t_sh};
    sgn   = sum[FXP_WIDTH+1];
    abs_v = sgn ? -sum : sum;
    // abs_v[FXP_WIDTH+1] can never be set; folding it in keeps every bit observed
    carry = abs_v[FXP_WIDTH+1] | abs_v[FXP_WIDTH];
    fx    = carry ? abs_v[FXP_WIDTH:1] : abs_v[FXP_WIDTH-1:0];
    e_w   = {1'b0, e_max} + (EXP_WIDTH+1)'(carry);
    if (e_w[EXP_WIDTH]) begin
      res = {1'b1, sgn, {EXP_WIDTH{1'b1}}, {FXP_WIDTH{1'b1}}};
    end else begin
      e_n = e_w[EXP_WIDTH-1:0];
      for (int i = 0; i < FXP_WIDTH; i++) begin
        if (!fx[FXP_WIDTH-1] && (e_n != {EXP_WIDTH{1'b0}})) begin
          fx  = fx << 1'b1;
          e_n = e_n - EXP_WIDTH'(1'b1);
        end else begin
          fx  = fx;
        end
      end
      if (fx == {FXP_WIDTH{1'b0}}) begin
        res = {(FP_WIDTH+1){1'b0}};
      end else begin
        res = {1'b0, sgn, e_n, fx};
      end
    end
    return res;
  endfunction

  // Pairwise reduction, level by level, lanes (2j, 2j+1) feeding slot j.
  function automatic logic [FP_WIDTH:0] tree_reduce(input logic [LANES*FP_WIDTH-1:0] d);
    logic [FP_WIDTH-1:0] v [LANES];
    logic [FP_WIDTH:0]   r;
    logic                ovf;
    ovf = 1'b0;
    for (int i = 0; i < LANES; i++) v[i] = d[i*FP_WIDTH +: FP_WIDTH];
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        r    = fp_add(v[2*j], v[2*j+1]);
        v[j] = r[FP_WIDTH-1:0];
        ovf  = ovf | r[FP_WIDTH];
      end
    end
    return {ovf, v[0]};
  endfunction

  logic                s1_valid_r, s1_last_r, s1_ovf_r;
  logic [FP_WIDTH-1:0] s1_sum_r;
  logic [FP_WIDTH-1:0] acc_r;
  logic                first_r, sticky_r;
  logic [FP_WIDTH:0]   tree_s, acc_add_s;
  logic [FP_WIDTH-1:0] acc_next_s;
  logic                sticky_next_s, s1_stall_s, s1_take_s;

  // Combinational datapath of both stages.
  always_comb begin
    tree_s    = tree_reduce(in_data);
    acc_add_s = fp_add(acc_r, s1_sum_r);
  end

  // Handshake decisions and the next accumulator value.
  always_comb begin
    s1_stall_s = s1_valid_r && s1_last_r && out_valid && !out_ready;
    s1_take_s  = s1_valid_r && !s1_stall_s;
    in_ready   = !s1_valid_r || s1_take_s;
    if (first_r) begin
      acc_next_s = s1_sum_r;
    end else begin
      acc_next_s = acc_add_s[FP_WIDTH-1:0];
    end
    sticky_next_s = sticky_r | s1_ovf_r | (!first_r & acc_add_s[FP_WIDTH]);
  end

  // Stage 1: register the reduced beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_ovf_r   <= 1'b0;
      s1_sum_r   <= {FP_WIDTH{1'b0}};
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_last_r <= in_last;
        s1_ovf_r  <= tree_s[FP_WIDTH];
        s1_sum_r  <= tree_s[FP_WIDTH-1:0];
      end
    end
  end

  // Stage 2: running accumulation and the result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r        <= {FP_WIDTH{1'b0}};
      first_r      <= 1'b1;
      sticky_r     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= {FP_WIDTH{1'b0}};
      out_overflow <= 1'b0;
    end else begin
      if (s1_take_s && s1_last_r) begin
        out_data     <= acc_next_s;
        out_overflow <= sticky_next_s;
        out_valid    <= 1'b1;
        acc_r        <= {FP_WIDTH{1'b0}};
        first_r      <= 1'b1;
        sticky_r     <= 1'b0;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (s1_take_s) begin
          acc_r    <= acc_next_s;
          first_r  <= 1'b0;
          sticky_r <= sticky_next_s;
        end
      end
    end
  end

  assign busy = !first_r || s1_valid_r;

endmodule
